gated_clk_en_ctrl: RTL and testbench
====================================

// Module: gated_clk_en_ctrl
// PURPOSE
//  Drives the module_en input of one gated clock cell. Detects sustained
//  idleness of the clocked module and negotiates clock-off with a req/ack
//  handshake. Reopens the clock on a wake request and reports when the
//  restored clock is usable. Sits on the always-on clock beside the ICG.
// PARAMETERS
//  IDLE_THRESH  8  consecutive idle cycles before gate_req (2..2**CNT_W)
//  CNT_W        4  idle counter width
//  WAKE_LAT     2  cycles from module_en rise to clk_rdy rise (>=1)
// PORTS
//  forever_cpuclk        in   1  always-on clock, rising edge
//  cpurst_b              in   1  reset, asynchronous, active-low
//  global_en             in   1  global gating permission; 0 = never gate
//  pad_yy_gate_clk_en_b  in   1  DFT force-on; 1 = clock forced on
//  mod_busy              in   1  module has in-flight work
//  mod_wake_req          in   1  pending work needs the clock
//  mod_gate_ack          in   1  module quiesced; accepts clock-off
//  module_en             out  1  to ICG module_en; 1 = clock running
//  gate_req              out  1  request module to quiesce
//  clk_rdy               out  1  gated clock usable by requesters
//  clk_gated             out  1  status: clock currently off (state OFF)
// BEHAVIOUR
//  - allow = global_en & ~pad_yy_gate_clk_en_b; active = mod_busy | mod_wake_req
//  - All outputs registered. Reset: state RUN, idle_cnt 0, module_en 1,
//    gate_req 0, clk_rdy 1, clk_gated 0. Reset mid-operation from any state
//    forces those values asynchronously; no handshake on reset.
//  - FSM states RUN, REQ, OFF, WAKE:
//    RUN : idle_cnt++ each cycle with allow & ~active; clears to 0 on
//          active or ~allow. Saturates, no wrap. Counter at
//          IDLE_THRESH-1 with allow & ~active -> REQ (gate_req=1 next cycle).
//    REQ : gate_req=1, module_en=1, clk_rdy=1. active or ~allow -> RUN
//          (abort, gate_req drops next cycle, cnt=0). Else mod_gate_ack -> OFF.
//          Ack and wake in the same cycle: wake wins, go to RUN.
//    OFF : module_en=0, clk_rdy=0, gate_req=0, clk_gated=1. mod_wake_req or
//          ~allow -> WAKE. mod_busy is ignored (module unclocked).
//    WAKE: module_en=1, clk_rdy=0. Wake counter runs WAKE_LAT cycles,
//          then -> RUN with clk_rdy=1. ~allow does not shorten WAKE.
//  - Latency: module_en falls 1 cycle after ack sampled; module_en rises
//    1 cycle after wake sampled; clk_rdy rises WAKE_LAT cycles after that.
//  - mod_gate_ack outside REQ is ignored. ~allow at any time prevents
//    entry to REQ/OFF.
//  - module_en never toggles low while clk_rdy=1.
// STRUCTURE
//  - Shared package gated_clk_pkg: FSM state encoding (2-bit:
//    RUN=0, REQ=1, OFF=2, WAKE=3) and default IDLE_THRESH/WAKE_LAT
//    constants.
//  - One sub-module gated_clk_idle_cnt: saturating idle counter with
//    clear and terminal-count output.
//  - FSM and wake counter live inline in this block.
// TESTING
//  1 reset release, allow=1, busy=0: 8 idle cycles -> gate_req=1 at
//    cycle 9; ack at cycle 11 -> module_en=0, clk_gated=1 at cycle 12.
//  2 In OFF, pulse mod_wake_req 1 cycle -> module_en=1 next cycle;
//    clk_rdy=1 2 cycles later (WAKE_LAT=2).
//  3 busy pulse at idle cycle 6 -> counter clears; gate_req only after
//    8 further idle cycles.
//  4 In REQ, assert ack and wake_req together -> state RUN, module_en
//    stays 1, gate_req drops next cycle.
//  5 pad_yy_gate_clk_en_b=1 while OFF -> WAKE then RUN; stays RUN with
//    module_en=1 for 50 idle cycles; gate_req never asserts.
//  6 cpurst_b low mid-WAKE -> module_en=1, clk_rdy=1, gate_req=0
//    immediately, before the next clock edge.

Source files
------------

// File: rtl/gated_clk_pkg.sv
// Shared constants for the gated-clock enable controller: FSM encoding and
// default idle/wake timing.
package gated_clk_pkg;

  localparam int unsigned IDLE_THRESH_DEF = 8;
  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned WAKE_LAT_DEF    = 2;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_WAKE = 2'd3;

  // Gating is permitted only when globally enabled and not forced on by DFT.
  function automatic logic gate_allowed(input logic global_en, input logic force_on);
    return global_en & ~force_on;
  endfunction

endpackage

// File: rtl/gated_clk_idle_cnt.sv
// Saturating idle-cycle counter with synchronous clear; term_c flags the
// increment that completes THRESH consecutive idle cycles.
module gated_clk_idle_cnt #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned THRESH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic term_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign term_c = inc & ~clr & (cnt_q == CNT_W'(THRESH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gated_clk_en_ctrl.sv
// Drives an ICG module_en: detects sustained idleness, negotiates clock-off
// via gate_req/ack, and reopens the clock on wake with a settle delay.
module gated_clk_en_ctrl
  import gated_clk_pkg::*;
#(
  parameter int unsigned IDLE_THRESH = IDLE_THRESH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WAKE_LAT    = WAKE_LAT_DEF
) (
  input  logic forever_cpuclk,
  input  logic cpurst_b,
  input  logic global_en,
  input  logic pad_yy_gate_clk_en_b,
  input  logic mod_busy,
  input  logic mod_wake_req,
  input  logic mod_gate_ack,
  output logic module_en,
  output logic gate_req,
  output logic clk_rdy,
  output logic clk_gated
);

  localparam int unsigned WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              module_en_d, gate_req_d, clk_rdy_d, clk_gated_d;
  logic              allow_c, active_c, idle_inc_c, idle_term_c;

  always_comb begin
    allow_c    = gate_allowed(global_en, pad_yy_gate_clk_en_b);
    active_c   = mod_busy | mod_wake_req;
    idle_inc_c = (state_q == ST_RUN) & allow_c & ~active_c;
  end

  // Counter is held at zero outside RUN so every RUN entry starts fresh.
  gated_clk_idle_cnt #(
    .CNT_W  (CNT_W),
    .THRESH (IDLE_THRESH)
  ) u_idle_cnt (
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
    .inc    (idle_inc_c),
    .clr    (~idle_inc_c),
    .term_c (idle_term_c)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    case (state_q)
      ST_RUN: begin
        if (idle_term_c) state_d = ST_REQ;
      end
      ST_REQ: begin
        // Wake or loss of permission beats a simultaneous ack.
        if (active_c || !allow_c) begin
          state_d = ST_RUN;
        end else if (mod_gate_ack) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (mod_wake_req || !allow_c) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (wcnt_q == WCNT_W'(WAKE_LAT - 1)) begin
          state_d = ST_RUN;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    module_en_d = (state_d != ST_OFF);
    gate_req_d  = (state_d == ST_REQ);
    clk_rdy_d   = (state_d == ST_RUN) || (state_d == ST_REQ);
    clk_gated_d = (state_d == ST_OFF);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      module_en <= 1'b1;
      gate_req  <= 1'b0;
      clk_rdy   <= 1'b1;
      clk_gated <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      module_en <= module_en_d;
      gate_req  <= gate_req_d;
      clk_rdy   <= clk_rdy_d;
      clk_gated <= clk_gated_d;
    end
  end

endmodule

// File: tb/tb_gated_clk_en_ctrl.sv
// Self-checking bench for gated_clk_en_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_gated_clk_en_ctrl;

  localparam int IDLE_THRESH = 8;
  localparam int WAKE_LAT    = 2;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic global_en = 1'b0;
  logic pad       = 1'b0;
  logic busy      = 1'b0;
  logic wake      = 1'b0;
  logic ack       = 1'b0;
  logic module_en, gate_req, clk_rdy, clk_gated;

  always #5 clk = ~clk;

  gated_clk_en_ctrl #(
    .IDLE_THRESH (IDLE_THRESH),
    .CNT_W       (4),
    .WAKE_LAT    (WAKE_LAT)
  ) dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (rst_n),
    .global_en            (global_en),
    .pad_yy_gate_clk_en_b (pad),
    .mod_busy             (busy),
    .mod_wake_req         (wake),
    .mod_gate_ack         (ack),
    .module_en            (module_en),
    .gate_req             (gate_req),
    .clk_rdy              (clk_rdy),
    .clk_gated            (clk_gated)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: clock off flag, pending request flag, remaining
  // settle cycles and length of the current idle streak.
  bit m_off, m_req;
  int m_wake_left, m_idle;

  task automatic model_reset();
    m_off = 1'b0; m_req = 1'b0; m_wake_left = 0; m_idle = 0;
  endtask

  task automatic model_step();
    bit allow, active;
    allow  = global_en & ~pad;
    active = busy | wake;
    if (m_wake_left > 0) begin
      m_wake_left--;
    end else if (m_off) begin
      if (wake || !allow) begin
        m_off = 1'b0;
        m_wake_left = WAKE_LAT;
      end
    end else if (m_req) begin
      if (active || !allow) begin
        m_req = 1'b0;
      end else if (ack) begin
        m_req = 1'b0;
        m_off = 1'b1;
      end
    end else if (allow && !active) begin
      m_idle++;
      if (m_idle >= IDLE_THRESH) begin
        m_req  = 1'b1;
        m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
    if (m_req || m_off || m_wake_left > 0) m_idle = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("model module_en", module_en, !m_off);
        chk("model gate_req",  gate_req,  m_req);
        chk("model clk_rdy",   clk_rdy,   !m_off && (m_wake_left == 0));
        chk("model clk_gated", clk_gated, m_off);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " module_en"}, module_en, 1'b1);
    chk({tag, " gate_req"},  gate_req,  1'b0);
    chk({tag, " clk_rdy"},   clk_rdy,   1'b1);
    chk({tag, " clk_gated"}, clk_gated, 1'b0);
  endtask

  initial begin
    global_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Idle threshold then ack
    tick(7);
    chk("t1 gate_req cyc8", gate_req, 1'b0);
    tick(1);
    chk("t1 gate_req cyc9", gate_req, 1'b1);
    chk("t1 module_en cyc9", module_en, 1'b1);
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t1 module_en cyc12", module_en, 1'b0);
    chk("t1 clk_gated cyc12", clk_gated, 1'b1);
    chk("t1 clk_rdy cyc12", clk_rdy, 1'b0);

    // Wake pulse from OFF
    wake = 1'b1;
    tick(1);
    wake = 1'b0;
    chk("t2 module_en", module_en, 1'b1);
    chk("t2 clk_rdy w1", clk_rdy, 1'b0);
    tick(1);
    chk("t2 clk_rdy w2", clk_rdy, 1'b0);
    tick(1);
    chk("t2 clk_rdy w3", clk_rdy, 1'b1);
    chk("t2 clk_gated", clk_gated, 1'b0);

    // Busy pulse restarts the idle streak
    tick(5);
    busy = 1'b1;
    tick(1);
    busy = 1'b0;
    tick(7);
    chk("t3 gate_req early", gate_req, 1'b0);
    tick(1);
    chk("t3 gate_req", gate_req, 1'b1);

    // Ack and wake together: wake wins
    ack = 1'b1; wake = 1'b1;
    tick(1);
    ack = 1'b0; wake = 1'b0;
    chk("t4 gate_req", gate_req, 1'b0);
    chk("t4 module_en", module_en, 1'b1);
    chk("t4 clk_gated", clk_gated, 1'b0);
    tick(8);
    chk("t4 regate req", gate_req, 1'b1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4 regate off", clk_gated, 1'b1);

    // DFT force-on while OFF
    pad = 1'b1;
    tick(1);
    chk("t5 module_en", module_en, 1'b1);
    chk("t5 clk_rdy wake", clk_rdy, 1'b0);
    tick(2);
    chk("t5 clk_rdy", clk_rdy, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("t5 gate_req", gate_req, 1'b0);
      chk("t5 module_en hold", module_en, 1'b1);
    end
    pad = 1'b0;

    // Async reset in WAKE
    tick(8);
    chk("t6 gate_req", gate_req, 1'b1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    wake = 1'b1;
    tick(1);
    wake = 1'b0;
    chk("t6 in wake rdy", clk_rdy, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6 async");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      global_en = ($urandom_range(0, 99) < 95);
      pad       = ($urandom_range(0, 99) < 3);
      busy      = ($urandom_range(0, 99) < 12);
      wake      = ($urandom_range(0, 99) < 5);
      ack       = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rand async");
        #3 rst_n = 1'b1;
      end
    end

    tick(1);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
